// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tap_controller
// Description : IEEE 1149.1-style TAP state machine with falling-edge control
//               outputs and glitch-free gated DR/IR shift clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_controller (
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output logic [3:0] state,
    output logic       tlReset,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       updateDR,
    output logic       captureIR,
    output logic       shiftIR,
    output logic       updateIR,
    output logic       clockDR,
    output logic       clockIR,
    output logic       select,
    output logic       tdoEn
);

    localparam logic [3:0] c_TLR   = 4'hF;
    localparam logic [3:0] c_RTI   = 4'hC;
    localparam logic [3:0] c_SELDR = 4'h7;
    localparam logic [3:0] c_CAPDR = 4'h6;
    localparam logic [3:0] c_SHDR  = 4'h2;
    localparam logic [3:0] c_EX1DR = 4'h1;
    localparam logic [3:0] c_PAUDR = 4'h3;
    localparam logic [3:0] c_EX2DR = 4'h0;
    localparam logic [3:0] c_UPDDR = 4'h5;
    localparam logic [3:0] c_SELIR = 4'h4;
    localparam logic [3:0] c_CAPIR = 4'hE;
    localparam logic [3:0] c_SHIR  = 4'hA;
    localparam logic [3:0] c_EX1IR = 4'h9;
    localparam logic [3:0] c_PAUIR = 4'hB;
    localparam logic [3:0] c_EX2IR = 4'h8;
    localparam logic [3:0] c_UPDIR = 4'hD;

    logic [3:0] r_state;
    logic [3:0] w_next_state;

    logic w_tl_reset, w_capture_dr, w_shift_dr, w_update_dr;
    logic w_capture_ir, w_shift_ir, w_update_ir, w_select, w_tdo_en;

    logic r_tl_reset, r_capture_dr, r_shift_dr, r_update_dr;
    logic r_capture_ir, r_shift_ir, r_update_ir, r_select, r_tdo_en;
    logic r_en_dr, r_en_ir;

    always_ff @(posedge tck or posedge reset) begin
        if (reset) r_state <= c_TLR;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = c_TLR;
        case (r_state)
            c_TLR:   w_next_state = tms ? c_TLR   : c_RTI;
            c_RTI:   w_next_state = tms ? c_SELDR : c_RTI;
            c_SELDR: w_next_state = tms ? c_SELIR : c_CAPDR;
            c_CAPDR: w_next_state = tms ? c_EX1DR : c_SHDR;
            c_SHDR:  w_next_state = tms ? c_EX1DR : c_SHDR;
            c_EX1DR: w_next_state = tms ? c_UPDDR : c_PAUDR;
            c_PAUDR: w_next_state = tms ? c_EX2DR : c_PAUDR;
            c_EX2DR: w_next_state = tms ? c_UPDDR : c_SHDR;
            c_UPDDR: w_next_state = tms ? c_SELDR : c_RTI;
            c_SELIR: w_next_state = tms ? c_TLR   : c_CAPIR;
            c_CAPIR: w_next_state = tms ? c_EX1IR : c_SHIR;
            c_SHIR:  w_next_state = tms ? c_EX1IR : c_SHIR;
            c_EX1IR: w_next_state = tms ? c_UPDIR : c_PAUIR;
            c_PAUIR: w_next_state = tms ? c_EX2IR : c_PAUIR;
            c_EX2IR: w_next_state = tms ? c_UPDIR : c_SHIR;
            c_UPDIR: w_next_state = tms ? c_SELDR : c_RTI;
            default: w_next_state = c_TLR;
        endcase
    end

    always_comb begin
        w_tl_reset   = (r_state == c_TLR);
        w_capture_dr = (r_state == c_CAPDR);
        w_shift_dr   = (r_state == c_SHDR);
        w_update_dr  = (r_state == c_UPDDR);
        w_capture_ir = (r_state == c_CAPIR);
        w_shift_ir   = (r_state == c_SHIR);
        w_update_ir  = (r_state == c_UPDIR);
        w_select     = (r_state == c_SELIR) || (r_state == c_CAPIR) ||
                       (r_state == c_SHIR)  || (r_state == c_EX1IR) ||
                       (r_state == c_PAUIR) || (r_state == c_EX2IR) ||
                       (r_state == c_UPDIR);
        w_tdo_en     = w_shift_dr || w_shift_ir;
    end

    // Controls move on the falling edge so they are settled half a cycle
    // before the rising tck that consumes them.
    always_ff @(negedge tck or posedge reset) begin
        if (reset) begin
            r_tl_reset   <= 1'b1;
            r_capture_dr <= 1'b0;
            r_shift_dr   <= 1'b0;
            r_update_dr  <= 1'b0;
            r_capture_ir <= 1'b0;
            r_shift_ir   <= 1'b0;
            r_update_ir  <= 1'b0;
            r_select     <= 1'b0;
            r_tdo_en     <= 1'b0;
            r_en_dr      <= 1'b0;
            r_en_ir      <= 1'b0;
        end else begin
            r_tl_reset   <= w_tl_reset;
            r_capture_dr <= w_capture_dr;
            r_shift_dr   <= w_shift_dr;
            r_update_dr  <= w_update_dr;
            r_capture_ir <= w_capture_ir;
            r_shift_ir   <= w_shift_ir;
            r_update_ir  <= w_update_ir;
            r_select     <= w_select;
            r_tdo_en     <= w_tdo_en;
            r_en_dr      <= w_capture_dr || w_shift_dr;
            r_en_ir      <= w_capture_ir || w_shift_ir;
        end
    end

    // Enables only change while tck is low, so the AND cannot produce runt pulses.
    assign clockDR   = tck & r_en_dr;
    assign clockIR   = tck & r_en_ir;

    assign state     = r_state;
    assign tlReset   = r_tl_reset;
    assign captureDR = r_capture_dr;
    assign shiftDR   = r_shift_dr;
    assign updateDR  = r_update_dr;
    assign captureIR = r_capture_ir;
    assign shiftIR   = r_shift_ir;
    assign updateIR  = r_update_ir;
    assign select    = r_select;
    assign tdoEn     = r_tdo_en;

endmodule
`default_nettype wire

// File: tb/tb_tap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_controller
// Description : Scoreboard bench for tap_controller (state queue + ID register).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_controller;

    localparam logic [31:0] c_ID = 32'h4BA0_0477;

    logic       tck, reset, tms;
    logic [3:0] state;
    logic       tlReset, captureDR, shiftDR, updateDR;
    logic       captureIR, shiftIR, updateIR, clockDR, clockIR, select, tdoEn;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_state;
    logic [3:0] exp_q [$];

    int          n_dr, n_dr_cap, n_dr_sh, n_ir, sh_idx;
    logic [31:0] id_sr, tdo_bits;

    logic [3:0] tgt  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    logic [7:0] path [16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                              8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
    int         plen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

    tap_controller dut (
        .tck       (tck),
        .reset     (reset),
        .tms       (tms),
        .state     (state),
        .tlReset   (tlReset),
        .captureDR (captureDR),
        .shiftDR   (shiftDR),
        .updateDR  (updateDR),
        .captureIR (captureIR),
        .shiftIR   (shiftIR),
        .updateIR  (updateIR),
        .clockDR   (clockDR),
        .clockIR   (clockIR),
        .select    (select),
        .tdoEn     (tdoEn)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Behavioural 32-bit ID register driven by the gated DR clock.
    always @(posedge clockDR) begin
        n_dr = n_dr + 1;
        if (captureDR) begin
            n_dr_cap = n_dr_cap + 1;
            id_sr    = c_ID;
        end else if (shiftDR) begin
            n_dr_sh = n_dr_sh + 1;
            if (sh_idx < 32) tdo_bits[sh_idx] = id_sr[0];
            sh_idx = sh_idx + 1;
            id_sr  = {1'b0, id_sr[31:1]};
        end
    end

    always @(posedge clockIR) n_ir = n_ir + 1;

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic t);
        case (s)
            4'hF: return t ? 4'hF : 4'hC;
            4'hC: return t ? 4'h7 : 4'hC;
            4'h7: return t ? 4'h4 : 4'h6;
            4'h4: return t ? 4'hF : 4'hE;
            4'h6: return t ? 4'h1 : 4'h2;
            4'h2: return t ? 4'h1 : 4'h2;
            4'h1: return t ? 4'h5 : 4'h3;
            4'h3: return t ? 4'h0 : 4'h3;
            4'h0: return t ? 4'h5 : 4'h2;
            4'h5: return t ? 4'h7 : 4'hC;
            4'hE: return t ? 4'h9 : 4'hA;
            4'hA: return t ? 4'h9 : 4'hA;
            4'h9: return t ? 4'hD : 4'hB;
            4'hB: return t ? 4'h8 : 4'hB;
            4'h8: return t ? 4'hD : 4'hA;
            default: return t ? 4'h7 : 4'hC;
        endcase
    endfunction

    // {tlReset,capDR,shDR,updDR,capIR,shIR,updIR,select,tdoEn}
    function automatic logic [8:0] model_outs(input logic [3:0] s);
        case (s)
            4'hF: return 9'b1_000_000_0_0;
            4'h6: return 9'b0_100_000_0_0;
            4'h2: return 9'b0_010_000_0_1;
            4'h5: return 9'b0_001_000_0_0;
            4'hE: return 9'b0_000_100_1_0;
            4'hA: return 9'b0_000_010_1_1;
            4'hD: return 9'b0_000_001_1_0;
            4'h4, 4'h9, 4'hB, 4'h8: return 9'b0_000_000_1_0;
            default: return 9'b0_000_000_0_0;
        endcase
    endfunction

    task automatic rise(input logic v);
        logic [3:0] e;
        tms       = v;
        exp_state = model_next(exp_state, v);
        exp_q.push_back(exp_state);
        @(posedge tck); #1;
        e = exp_q.pop_front();
        total++;
        if (state !== e) begin
            bad++;
            $display("FAIL state_step: got %h want %h", state, e);
        end
    endtask

    task automatic fall();
        @(negedge tck); #1;
    endtask

    task automatic step(input logic v);
        rise(v);
        fall();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_state = 4'hF;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [8:0] o;
        @(posedge tck); #1;
        o = {tlReset, captureDR, shiftDR, updateDR, captureIR, shiftIR, updateIR, select, tdoEn};
        total++;
        if (state !== 4'hF) begin bad++; $display("FAIL reset_state: got %h want f", state); end
        total++;
        if (o !== 9'b1_000_000_0_0) begin bad++; $display("FAIL reset_outs: got %b want 100000000", o); end
        total++;
        if ({clockDR, clockIR} !== 2'b00) begin
            bad++; $display("FAIL reset_clocks: got %b want 00", {clockDR, clockIR});
        end
        fall();
        reset     = 1'b0;
        exp_state = 4'hF;
    endtask

    task automatic test_dr_capture();
        n_dr = 0; n_dr_cap = 0; n_dr_sh = 0; sh_idx = 0;
        step(1'b0);
        total++;
        if (tlReset !== 1'b0) begin bad++; $display("FAIL tlreset_clear: got %b want 0", tlReset); end
        step(1'b1);
        step(1'b0);
        total++;
        if (captureDR !== 1'b1) begin bad++; $display("FAIL capture_dr: got %b want 1", captureDR); end
        rise(1'b0);
        total++;
        if (n_dr !== 1 || n_dr_cap !== 1) begin
            bad++; $display("FAIL capture_pulse: got pulses=%0d cap=%0d want 1/1", n_dr, n_dr_cap);
        end
        fall();
        total++;
        if ({shiftDR, tdoEn, captureDR} !== 3'b110) begin
            bad++; $display("FAIL shift_dr_entry: got %b want 110", {shiftDR, tdoEn, captureDR});
        end
    endtask

    task automatic test_dr_shift();
        repeat (32) step(1'b0);
        step(1'b1);
        total++;
        if (n_dr_sh !== 33 || n_dr !== 34) begin
            bad++; $display("FAIL shift_pulses: got shifts=%0d total=%0d want 33/34", n_dr_sh, n_dr);
        end
        total++;
        if (tdo_bits !== c_ID) begin bad++; $display("FAIL id_shift_out: got %h want %h", tdo_bits, c_ID); end
        total++;
        if (shiftDR !== 1'b0) begin bad++; $display("FAIL shift_dr_exit: got %b want 0", shiftDR); end
    endtask

    task automatic test_update();
        n_dr = 0;
        rise(1'b1);
        total++;
        if (updateDR !== 1'b0) begin bad++; $display("FAIL update_early: got %b want 0", updateDR); end
        fall();
        total++;
        if (updateDR !== 1'b1) begin bad++; $display("FAIL update_rise: got %b want 1", updateDR); end
        rise(1'b0);
        total++;
        if (updateDR !== 1'b1) begin bad++; $display("FAIL update_hold: got %b want 1", updateDR); end
        fall();
        total++;
        if (updateDR !== 1'b0) begin bad++; $display("FAIL update_fall: got %b want 0", updateDR); end
        total++;
        if (n_dr !== 0) begin bad++; $display("FAIL update_no_clock: got %0d want 0", n_dr); end
    endtask

    task automatic test_ir_path();
        n_dr = 0; n_ir = 0;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        total++;
        if ({captureIR, select} !== 2'b11) begin
            bad++; $display("FAIL capture_ir: got %b want 11", {captureIR, select});
        end
        step(1'b0);
        total++;
        if ({select, tdoEn, shiftIR} !== 3'b111) begin
            bad++; $display("FAIL shift_ir: got %b want 111", {select, tdoEn, shiftIR});
        end
        total++;
        if ({captureDR, shiftDR} !== 2'b00 || n_dr !== 0) begin
            bad++; $display("FAIL ir_dr_quiet: got %b pulses=%0d want 00/0", {captureDR, shiftDR}, n_dr);
        end
        total++;
        if (n_ir !== 1) begin bad++; $display("FAIL ir_capture_pulse: got %0d want 1", n_ir); end
    endtask

    task automatic test_tlr_all();
        logic [8:0] o;
        logic [7:0] p;
        for (int i = 0; i < 16; i++) begin
            do_reset();
            p = path[i];
            for (int j = 0; j < plen[i]; j++) step(p[j]);
            o = {tlReset, captureDR, shiftDR, updateDR, captureIR, shiftIR, updateIR, select, tdoEn};
            total++;
            if (state !== tgt[i] || o !== model_outs(tgt[i])) begin
                bad++;
                $display("FAIL reach_state_%h: got %h/%b want %h/%b", tgt[i], state, o, tgt[i], model_outs(tgt[i]));
            end
            repeat (5) step(1'b1);
            total++;
            if (state !== 4'hF || tlReset !== 1'b1) begin
                bad++; $display("FAIL five_tms_from_%h: got %h/%b want f/1", tgt[i], state, tlReset);
            end
        end
    endtask

    task automatic test_reset_midshift();
        do_reset();
        step(1'b0); step(1'b1); step(1'b0); step(1'b0); step(1'b0);
        tms = 1'b0;
        @(posedge tck); #1;
        total++;
        if (clockDR !== 1'b1) begin bad++; $display("FAIL midshift_clock: got %b want 1", clockDR); end
        reset = 1'b1;
        #1;
        total++;
        if (state !== 4'hF || clockDR !== 1'b0) begin
            bad++; $display("FAIL async_reset: got %h/%b want f/0", state, clockDR);
        end
        reset = 1'b0;
        exp_state = 4'hF;
        exp_q.delete();
        n_dr = 0;
        fall();
        repeat (3) step(1'b1);
        total++;
        if (n_dr !== 0 || shiftDR !== 1'b0) begin
            bad++; $display("FAIL post_reset_quiet: got pulses=%0d shift=%b want 0/0", n_dr, shiftDR);
        end
    endtask

    initial begin
        reset = 1'b1;
        tms   = 1'b1;
        n_dr = 0; n_dr_cap = 0; n_dr_sh = 0; n_ir = 0; sh_idx = 0;
        id_sr = '0; tdo_bits = '0;
        exp_state = 4'hF;
        test_reset();
        test_dr_capture();
        test_dr_shift();
        test_update();
        test_ir_path();
        test_tlr_all();
        test_reset_midshift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 No parameters; state encoding fixed per REQ-010.
REQ-002 tck  input  1  test clock; sole clock; state advances on rising edge, control outputs change on falling edge.
REQ-003 reset  input  1  asynchronous, active-high; forces Test-Logic-Reset immediately.
REQ-004 tms  input  1  test mode select, sampled on rising tck.
REQ-005 state  output  4  current TAP state, encoding per REQ-010.
REQ-006 tlReset  output  1  high while in Test-Logic-Reset.
REQ-007 captureDR, shiftDR, updateDR, captureIR, shiftIR, updateIR  output  1 each  decoded DR/IR path controls.
REQ-008 clockDR, clockIR  output  1 each  gated tck for the DR/IR shift registers.
REQ-009 select  output  1  high in IR-path states (SelIR..UpdIR); tdoEn  output  1  high in ShiftDR/ShiftIR.

Function
REQ-010 16-state FSM, 4-bit encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
REQ-011 Transitions (tms=0 / tms=1): TLR->RTI/TLR; RTI->RTI/SelDR; SelDR->CapDR/SelIR; SelIR->CapIR/TLR.
REQ-012 DR column: CapDR->ShDR/Ex1DR; ShDR->ShDR/Ex1DR; Ex1DR->PauDR/UpdDR; PauDR->PauDR/Ex2DR; Ex2DR->ShDR/UpdDR; UpdDR->RTI/SelDR.
REQ-013 IR column identical to DR column with IR states substituted; UpdIR->RTI/SelDR.
REQ-014 state register updates only on rising tck; state output is that register.
REQ-015 captureDR, shiftDR, captureIR, shiftIR, tlReset, select, tdoEn registered on falling tck from current state; each valid from the falling edge within its state through the following rising edge.
REQ-016 updateDR/updateIR registered on falling tck: high from the falling edge in UpdDR/UpdIR until the next falling edge; rising edge of updateDR marks the parallel update.
REQ-017 clockDR = tck AND enDR; enDR registered on falling tck, high when state is CapDR or ShDR; clockIR likewise for CapIR/ShIR.
REQ-018 Consequence: clockDR rising edge coincides with the rising tck that exits CapDR/ShDR, with captureDR (resp. shiftDR) already stable high, so a DR loads on exit from CapDR and shifts on each exit from ShDR.
REQ-019 Enables change only while tck is low; clockDR/clockIR glitch-free, no partial pulses.
REQ-020 Five consecutive rising tck with tms=1 reach TLR from any state.
REQ-021 At most one of capture/shift/update per path high at any time; DR and IR path signals never simultaneously high.
REQ-022 All 16 encodings legal; no unreachable or lock-up state.

Reset
REQ-023 reset high: state=F, tlReset=1, all other outputs 0, enDR=enIR=0 (clockDR=clockIR=0), asynchronously, regardless of tck phase.
REQ-024 Reset asserted mid-shift terminates shift; no clockDR/clockIR pulse thereafter until a new CapDR/CapIR.
REQ-025 After reset deasserts, first rising tck with tms=0 moves to RTI; tlReset clears on next falling tck.

Verification
REQ-026 Reset, tms sequence 0,1,0,0 -> state C,7,6,2; captureDR high across rising edge leaving 6; exactly one clockDR pulse at that edge.
REQ-027 From ShDR, 32 rising tck tms=0 then tms=1 -> 33 clockDR pulses after capture with shiftDR high; state 1; ID register shifts out 0x...1 LSB first (bit0=1).
REQ-028 Ex1DR, tms=1 -> state 5; updateDR rises on following falling tck, one tck period wide; clockDR stays 0.
REQ-029 From each of 16 states (reached by directed tms), five tms=1 clocks -> state F, tlReset=1.
REQ-030 IR path: tms 1,1,0,0 from RTI -> states 7,4,E,A; select=1, tdoEn=1 in A; captureDR/shiftDR/clockDR remain 0.
REQ-031 reset pulsed while tck high in ShDR -> state F and clockDR low immediately; no clockDR edge on following tck.
